serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that feeds the team's single-bit full-adder cell one bit pair per clock and consumes its Sum/Cout outputs.
- Captures two WIDTH-bit operands on a start pulse.
- Streams LSB-first operand bits plus the registered carry to the full adder.
- Shifts each returned Sum bit into a result register and feeds Cout back as the next carry-in.
- Signals completion with a one-cycle done pulse.
- Sits between a word-level requester and the bit-level full-adder cell; the two are connected at the parent level through the fa_* ports.

---
 rtl/serial_adder_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// Captures two WIDTH-bit operands on start and feeds an external single-bit
// full-adder cell one LSB-first bit pair per clock. Each Sum bit returned by
// the cell is shifted into a result register, and Cout is fed back as the next
// carry-in. A one-cycle done pulse marks the point where sum/cout are updated.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns
// the operation into A-B in two's complement. In that mode cout=1 means no borrow.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    // Only WIDTH-1 bits are kept, because the last Sum bit goes straight into 'sum'.
    logic [WIDTH-2:0]   sum_sh;
    logic [WIDTH-1:0]   sum_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;

    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    // Choose the B operand and initial carry to load. Subtraction inverts B and forces carry-in to 1.
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs. The fa_* outputs are driven only while shifting.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        last_bit   = (cnt == CNT_W'(WIDTH - 1));
        sum_next   = {fa_sum, sum_sh};
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture the operands on an accepted start, then shift one bit pair per cycle.
    // The final Sum bit and Cout are committed to sum/cout on the last shift edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= carry_load;
                        sum_sh <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next[WIDTH-1:1];
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= sum_next;
                        cout <= fa_cout;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: testbench for serial_adder_ctrl with WIDTH=8.
// A behavioural full-adder cell is wired to the fa_* ports.
// Results are predicted by whole-word arithmetic (a + b + cin). The expected
// carry into each bit comes from adding the masked lower bits of the operands.
// The subtraction tests run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural model of the single-bit full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation and checks the fa_* stream on every shift cycle,
    // the done cycle and the following idle cycle.
    // When retrig is set, a second start is pulsed during the shift phase.
    // That pulse must be ignored.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                 input logic tcin, input logic tsub, input bit retrig);
        int b_eff;
        int c0;
        int total;
        int mask;
        int exp_carry;
        b_eff = tsub ? int'(~tb_v) : int'(tb_v);
        c0    = tsub ? 1 : int'(tcin);
        total = int'(ta) + b_eff + c0;

        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tcin;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = tsub;
`endif
        start = 1'b1;

        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                cin   = 1'($urandom);
            end
            if (retrig && i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end
            if (retrig && i == 4) begin
                start = 1'b0;
            end
            mask      = (1 << i) - 1;
            exp_carry = (((int'(ta) & mask) + (b_eff & mask) + c0) >> i) & 1;
            checkOutput($sformatf("shift%0d_busy", i), 32'(busy), 32'd1);
            checkOutput($sformatf("shift%0d_done", i), 32'(done), 32'd0);
            checkOutput($sformatf("shift%0d_fa_a", i), 32'(fa_a), 32'(ta[i]));
            checkOutput($sformatf("shift%0d_fa_b", i), 32'(fa_b), 32'((b_eff >> i) & 1));
            checkOutput($sformatf("shift%0d_fa_cin", i), 32'(fa_cin), 32'(exp_carry));
            checkOutput($sformatf("shift%0d_sum_hold", i), 32'(sum), 32'(prev_sum));
            checkOutput($sformatf("shift%0d_cout_hold", i), 32'(cout), 32'(prev_cout));
        end

        prev_sum  = total[WIDTH-1:0];
        prev_cout = total[WIDTH];

        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_sum", 32'(sum), 32'(prev_sum));
        checkOutput("done_cout", 32'(cout), 32'(prev_cout));
        checkOutput("done_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);

        @(negedge clk);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        checkOutput("idle_sum", 32'(sum), 32'(prev_sum));
        checkOutput("idle_cout", 32'(cout), 32'(prev_cout));
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        prev_sum  = '0;
        prev_cout = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        rst_n = 1'b1;

        $display("[TB] directed additions");
        applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_sum_const", 32'(sum), 32'h7F);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_cout_const", 32'(cout), 32'd1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_sum_const", 32'(sum), 32'hFF);

        $display("[TB] start ignored while busy");
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        checkOutput("retrig_sum_const", 32'(sum), 32'h46);
        repeat (3) begin
            @(negedge clk);
            checkOutput("retrig_no_extra_done", 32'(done), 32'd0);
            checkOutput("retrig_sum_hold", 32'(sum), 32'h46);
            checkOutput("retrig_cout_hold", 32'(cout), 32'd0);
        end

        $display("[TB] reset during shift");
        @(negedge clk);
        a     = 8'hF0;
        b     = 8'h0F;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_sum", 32'(sum), 32'd0);
        checkOutput("midreset_cout", 32'(cout), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            checkOutput("postreset_no_done", 32'(done), 32'd0);
            checkOutput("postreset_idle", 32'(busy), 32'd0);
        end
        applyStimulus(8'h21, 8'h13, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        $display("[TB] subtraction");
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        checkOutput("sub1_sum_const", 32'(sum), 32'h0F);
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        checkOutput("sub2_cout_const", 32'(cout), 32'd0);
`endif

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            logic rsub;
`ifdef SERIAL_ADDER_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rsub, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
